// File: rtl/sme_job_sched.sv
// Round-robin job scheduler that time-shares one string-matching engine among NREQ requesters.
// Streams buffered string/pattern chars to the engine and returns tagged results with a hang timeout.
module sme_job_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [IDW-1:0]    i_wr_id,
  input  logic              i_wr_sel,
  input  logic [4:0]        i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [NREQ-1:0]   i_go,
  input  logic [NREQ*6-1:0] i_slen,
  input  logic [NREQ*4-1:0] i_plen,
  input  logic [NREQ-1:0]   i_keep_str,
  output logic [NREQ-1:0]   o_pending,
  output logic              o_done_valid,
  output logic [IDW-1:0]    o_done_id,
  output logic              o_done_match,
  output logic [4:0]        o_done_index,
  output logic              o_done_err,
  output logic [7:0]        o_eng_chardata,
  output logic              o_eng_isstring,
  output logic              o_eng_ispattern,
  output logic              o_eng_rst,
  input  logic              i_eng_valid,
  input  logic              i_eng_match,
  input  logic [4:0]        i_eng_match_index
);

  localparam int unsigned WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StSendS,
    StSendP,
    StWait,
    StResp
  } state_e;

  logic [7:0]      r_str [NREQ][32];
  logic [7:0]      r_pat [NREQ][8];
  logic [5:0]      r_slen [NREQ];
  logic [3:0]      r_plen [NREQ];
  logic [NREQ-1:0] r_keep;

  state_e          r_state;
  logic [NREQ-1:0] r_pending;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [5:0]      r_cur_slen;
  logic [3:0]      r_cur_plen;
  logic [5:0]      r_cnt;
  logic [WW-1:0]   r_wcnt;
  logic            r_str_res;
  logic            r_done_valid;
  logic [IDW-1:0]  r_done_id;
  logic            r_done_match;
  logic [4:0]      r_done_index;
  logic            r_done_err;
  logic [7:0]      r_chardata;
  logic            r_isstr;
  logic            r_ispat;
  logic            r_eng_rst;

  logic [NREQ-1:0] w_go_acc;
  logic            w_wr_ok;
  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_id;
  logic [NREQ-1:0] w_gnt_mask;
  logic [NREQ-1:0] w_id_mask;
  logic [5:0]      w_g_slen;
  logic [3:0]      w_g_plen;
  logic            w_g_keep;
  logic            w_bad;

  assign w_go_acc = i_go & ~r_pending;
  assign w_wr_ok  = (int'(i_wr_id) < NREQ) && !r_pending[i_wr_id];

  // Scan from farthest to nearest so the id closest after the pointer wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (r_pending[IDW'((int'(r_ptr) + k) % NREQ)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_gnt_mask = NREQ'(1) << w_gnt_id;
    w_id_mask  = NREQ'(1) << r_id;
    w_g_slen   = r_slen[w_gnt_id];
    w_g_plen   = r_plen[w_gnt_id];
    w_g_keep   = r_keep[w_gnt_id];
    w_bad      = (w_g_plen == 4'd0) || (w_g_plen > 4'd8) || (w_g_slen > 6'd32) ||
                 ((w_g_slen == 6'd0) && !w_g_keep) || (w_g_keep && !r_str_res);
  end

  // Buffer and length storage carry no reset: contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_ok) begin
      if (i_wr_sel) r_pat[i_wr_id][i_wr_addr[2:0]] <= i_wr_data;
      else          r_str[i_wr_id][i_wr_addr]      <= i_wr_data;
    end
    for (int r = 0; r < NREQ; r++) begin
      if (w_go_acc[r]) begin
        r_slen[r] <= i_slen[r*6 +: 6];
        r_plen[r] <= i_plen[r*4 +: 4];
        r_keep[r] <= i_keep_str[r];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_pending    <= '0;
      r_ptr        <= IDW'(NREQ - 1);
      r_id         <= '0;
      r_cur_slen   <= '0;
      r_cur_plen   <= '0;
      r_cnt        <= '0;
      r_wcnt       <= '0;
      r_str_res    <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_done_match <= 1'b0;
      r_done_index <= '0;
      r_done_err   <= 1'b0;
      r_chardata   <= '0;
      r_isstr      <= 1'b0;
      r_ispat      <= 1'b0;
      r_eng_rst    <= 1'b0;
    end else begin
      r_pending <= r_pending | w_go_acc;
      case (r_state)
        StIdle: begin
          if (|r_pending) r_state <= StArb;
        end
        StArb: begin
          if (!w_gnt_found) begin
            r_state <= StIdle;
          end else begin
            r_id       <= w_gnt_id;
            r_ptr      <= w_gnt_id;
            r_cur_slen <= w_g_slen;
            r_cur_plen <= w_g_plen;
            r_cnt      <= 6'd1;
            if (w_bad) begin
              r_done_valid <= 1'b1;
              r_done_id    <= w_gnt_id;
              r_done_match <= 1'b0;
              r_done_index <= '0;
              r_done_err   <= 1'b1;
              r_pending    <= (r_pending | w_go_acc) & ~w_gnt_mask;
              r_state      <= StResp;
            end else if (w_g_keep) begin
              r_ispat    <= 1'b1;
              r_chardata <= r_pat[w_gnt_id][0];
              r_state    <= StSendP;
            end else begin
              r_isstr    <= 1'b1;
              r_chardata <= r_str[w_gnt_id][0];
              r_state    <= StSendS;
            end
          end
        end
        StSendS: begin
          // The engine needs the pattern immediately after the last string char.
          if (r_cnt == r_cur_slen) begin
            r_isstr    <= 1'b0;
            r_ispat    <= 1'b1;
            r_chardata <= r_pat[r_id][0];
            r_cnt      <= 6'd1;
            r_str_res  <= 1'b1;
            r_state    <= StSendP;
          end else begin
            r_chardata <= r_str[r_id][r_cnt[4:0]];
            r_cnt      <= r_cnt + 6'd1;
          end
        end
        StSendP: begin
          if (r_cnt == {2'b00, r_cur_plen}) begin
            r_ispat    <= 1'b0;
            r_chardata <= '0;
            r_wcnt     <= '0;
            r_state    <= StWait;
          end else begin
            r_chardata <= r_pat[r_id][r_cnt[2:0]];
            r_cnt      <= r_cnt + 6'd1;
          end
        end
        StWait: begin
          if (i_eng_valid) begin
            r_done_valid <= 1'b1;
            r_done_id    <= r_id;
            r_done_match <= i_eng_match;
            r_done_index <= i_eng_match_index;
            r_done_err   <= 1'b0;
            r_pending    <= (r_pending | w_go_acc) & ~w_id_mask;
            r_state      <= StResp;
          end else if (r_wcnt == WW'(TIMEOUT - 1)) begin
            r_eng_rst    <= 1'b1;
            r_str_res    <= 1'b0;
            r_done_valid <= 1'b1;
            r_done_id    <= r_id;
            r_done_match <= 1'b0;
            r_done_index <= '0;
            r_done_err   <= 1'b1;
            r_pending    <= (r_pending | w_go_acc) & ~w_id_mask;
            r_state      <= StResp;
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
          end
        end
        StResp: begin
          r_done_valid <= 1'b0;
          r_eng_rst    <= 1'b0;
          r_state      <= (|r_pending) ? StArb : StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_pending       = r_pending;
  assign o_done_valid    = r_done_valid;
  assign o_done_id       = r_done_id;
  assign o_done_match    = r_done_match;
  assign o_done_index    = r_done_index;
  assign o_done_err      = r_done_err;
  assign o_eng_chardata  = r_chardata;
  assign o_eng_isstring  = r_isstr;
  assign o_eng_ispattern = r_ispat;
  assign o_eng_rst       = r_eng_rst;

endmodule

// File: tb/tb_sme_job_sched.sv
// Directed bench for sme_job_sched with a fixed-latency engine stub and a stream/result monitor.
module tb_sme_job_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_id = '0;
  logic        wr_sel = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  go = '0;
  logic [23:0] slen = '0;
  logic [15:0] plen = '0;
  logic [3:0]  keep = '0;
  logic [3:0]  pending;
  logic        done_valid;
  logic [1:0]  done_id;
  logic        done_match;
  logic [4:0]  done_index;
  logic        done_err;
  logic [7:0]  chardata;
  logic        isstring;
  logic        ispattern;
  logic        eng_rst;
  logic        eng_valid = 1'b0;
  logic        stub_match = 1'b0;
  logic [4:0]  stub_idx = '0;
  logic        stub_en = 1'b1;
  logic        prev_isp = 1'b0;
  logic        dly = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int go_cyc = 0;
  int last_p = 0;
  int s_cnt = 0;
  int p_cnt = 0;
  int both = 0;
  int idle_data = 0;
  int rst_cnt = 0;

  typedef struct {
    int id;
    int m;
    int idx;
    int err;
    int ns;
    int np;
    int lat;
    int rst;
    int wt;
  } done_t;

  done_t      dq[$];
  logic [7:0] sq[$];
  logic [7:0] pq[$];

  sme_job_sched #(.NREQ(4), .IDW(2), .TIMEOUT(256)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_wr_en(wr_en),
    .i_wr_id(wr_id),
    .i_wr_sel(wr_sel),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_go(go),
    .i_slen(slen),
    .i_plen(plen),
    .i_keep_str(keep),
    .o_pending(pending),
    .o_done_valid(done_valid),
    .o_done_id(done_id),
    .o_done_match(done_match),
    .o_done_index(done_index),
    .o_done_err(done_err),
    .o_eng_chardata(chardata),
    .o_eng_isstring(isstring),
    .o_eng_ispattern(ispattern),
    .o_eng_rst(eng_rst),
    .i_eng_valid(eng_valid),
    .i_eng_match(stub_match),
    .i_eng_match_index(stub_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: valid goes high 3 cycles after the last pattern char.
  always @(posedge clk) begin
    eng_valid <= 1'b0;
    prev_isp  <= ispattern;
    if (dly) begin
      eng_valid <= 1'b1;
      dly       <= 1'b0;
    end
    if (prev_isp && !ispattern && stub_en) dly <= 1'b1;
  end

  always @(negedge clk) begin
    if (reset) begin
      s_cnt <= 0;
      p_cnt <= 0;
    end else begin
      if (isstring) begin
        s_cnt <= s_cnt + 1;
        sq.push_back(chardata);
      end
      if (ispattern) begin
        p_cnt  <= p_cnt + 1;
        last_p <= cyc;
        pq.push_back(chardata);
      end
      if (isstring && ispattern) both <= both + 1;
      if (!isstring && !ispattern && chardata != 8'h00) idle_data <= idle_data + 1;
      if (eng_rst) rst_cnt <= rst_cnt + 1;
      if (done_valid) begin
        dq.push_back('{int'(done_id), int'(done_match), int'(done_index), int'(done_err),
                       s_cnt, p_cnt, cyc - go_cyc, int'(eng_rst), cyc - last_p});
        s_cnt <= 0;
        p_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input int id, input logic sel, input int addr, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_id   = id[1:0];
    wr_sel  = sel;
    wr_addr = addr[4:0];
    wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic load(input int id, input string s, input string p);
    for (int i = 0; i < s.len(); i++) wr(id, 1'b0, i, s[i]);
    for (int i = 0; i < p.len(); i++) wr(id, 1'b1, i, p[i]);
  endtask

  task automatic set_len(input int id, input int sl, input int pl, input logic k);
    slen[id*6 +: 6] = sl[5:0];
    plen[id*4 +: 4] = pl[3:0];
    keep[id]        = k;
  endtask

  task automatic fire(input logic [3:0] m);
    go     = m;
    go_cyc = cyc;
    step(1);
    go = '0;
  endtask

  task automatic wait_done(input int target, input int max_cyc);
    int k;
    k = 0;
    while (dq.size() < target && k < max_cyc) begin
      step(1);
      k++;
    end
    chk("wait_done", 32'(dq.size() >= target), 32'd1);
  endtask

  task automatic chk_done(input string tag, input int i, input int id, input int m,
                          input int idx, input int err);
    chk({tag, "_id"}, dq[i].id, id);
    chk({tag, "_match"}, dq[i].m, m);
    chk({tag, "_index"}, dq[i].idx, idx);
    chk({tag, "_err"}, dq[i].err, err);
  endtask

  initial begin
    int    base;
    int    k;
    string exp_s;

    // Reset state
    step(2);
    chk("rst_pending", pending, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_eng_pins", {chardata, isstring, ispattern, eng_rst}, 0);
    reset = 1'b0;
    step(2);
    chk("post_rst_outputs", {pending, done_valid, done_err, chardata, isstring, eng_rst}, 0);

    // Basic match
    load(0, "ab cd", "cd");
    stub_match = 1'b1;
    stub_idx   = 5'd3;
    set_len(0, 5, 2, 1'b0);
    fire(4'b0001);
    chk("basic_pending", pending, 4'b0001);
    wait_done(1, 40);
    chk_done("basic", 0, 0, 1, 3, 0);
    chk("basic_latency", dq[0].lat, 13);
    chk("basic_nstr", sq.size(), 5);
    chk("basic_npat", pq.size(), 2);
    exp_s = "ab cd";
    for (int i = 0; i < 5; i++) chk($sformatf("basic_str%0d", i), sq[i], exp_s[i]);
    chk("basic_pat0", pq[0], 8'h63);
    chk("basic_pat1", pq[1], 8'h64);
    step(1);
    chk("basic_pending_clr", pending, 0);

    // Round robin with r2 reusing r1's string
    load(1, "hello", "ll");
    load(2, "", "lo");
    load(3, "xyz", "z");
    stub_idx = 5'd5;
    sq.delete();
    pq.delete();
    set_len(1, 5, 2, 1'b0);
    set_len(2, 0, 2, 1'b1);
    set_len(3, 3, 1, 1'b0);
    fire(4'b1110);
    chk("rr_pending", pending, 4'b1110);
    wait_done(4, 120);
    chk_done("rr0", 1, 1, 1, 5, 0);
    chk_done("rr1", 2, 2, 1, 5, 0);
    chk_done("rr2", 3, 3, 1, 5, 0);
    chk("rr_keep_nstr", dq[2].ns, 0);
    chk("rr_keep_npat", dq[2].np, 2);
    chk("rr_r1_nstr", dq[1].ns, 5);
    chk("rr_r3_nstr", dq[3].ns, 3);
    chk("rr_str_total", sq.size(), 8);
    chk("rr_str_x", sq[5], 8'h78);
    chk("rr_keep_pat0", pq[2], 8'h6c);
    chk("rr_keep_pat1", pq[3], 8'h6f);
    step(1);
    chk("rr_pending_clr", pending, 0);

    // Invalid lengths: no engine traffic, result 3 cycles after go
    set_len(3, 3, 9, 1'b0);
    fire(4'b1000);
    wait_done(5, 20);
    chk_done("inv_plen", 4, 3, 0, 0, 1);
    chk("inv_plen_lat", dq[4].lat, 3);
    chk("inv_plen_traffic", dq[4].ns + dq[4].np, 0);
    set_len(1, 33, 2, 1'b0);
    fire(4'b0010);
    wait_done(6, 20);
    chk_done("inv_slen", 5, 1, 0, 0, 1);
    set_len(2, 0, 2, 1'b0);
    fire(4'b0100);
    wait_done(7, 20);
    chk_done("inv_zero", 6, 2, 0, 0, 1);
    chk("inv_zero_traffic", dq[6].ns + dq[6].np, 0);

    // Timeout
    stub_en = 1'b0;
    set_len(1, 5, 2, 1'b0);
    fire(4'b0010);
    wait_done(8, 400);
    chk_done("tmo", 7, 1, 0, 0, 1);
    chk("tmo_rst_with_done", dq[7].rst, 1);
    chk("tmo_wait_len", dq[7].wt, 257);
    chk("tmo_rst_cnt", rst_cnt, 1);
    stub_en = 1'b1;

    // keep_str after an engine reset has no resident string
    set_len(2, 0, 2, 1'b1);
    fire(4'b0100);
    wait_done(9, 20);
    chk_done("keep_norst", 8, 2, 0, 0, 1);
    chk("keep_norst_npat", dq[8].np, 0);

    // Writes and go to a pending requester are dropped
    stub_match = 1'b0;
    stub_idx   = 5'd9;
    sq.delete();
    pq.delete();
    base = dq.size();
    set_len(0, 5, 2, 1'b0);
    fire(4'b0001);
    wr(0, 1'b0, 0, 8'h7a);
    wr(0, 1'b1, 1, 8'h71);
    fire(4'b0001);
    wait_done(base + 1, 40);
    step(20);
    chk("prot_one_done", dq.size(), base + 1);
    chk_done("prot", base, 0, 0, 9, 0);
    fire(4'b0001);
    wait_done(base + 2, 40);
    chk("prot_rerun_nstr", sq.size(), 10);
    chk("prot_rerun_str0", sq[5], 8'h61);
    chk("prot_rerun_pat1", pq[3], 8'h64);

    // Reset in the middle of SEND_S
    base = dq.size();
    fire(4'b0001);
    k = 0;
    while (!isstring && k < 20) begin
      step(1);
      k++;
    end
    chk("mid_reach_sends", isstring, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_outputs", {done_valid, chardata, isstring, ispattern, eng_rst}, 0);
    step(2);
    reset = 1'b0;
    step(30);
    chk("mid_no_done", dq.size(), base);
    chk("mid_pending", pending, 0);

    chk("never_both_strobes", both, 0);
    chk("idle_chardata_zero", idle_data, 0);
    chk("rst_pulses_total", rst_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
